// File: rtl/demux_pkg.sv
// Shared constants and slot state encoding for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry skid-free buffer plus a delivered-beat counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  slot_state_e      r_state;
  slot_state_e      w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_drain;

  assign w_drain = (r_state == SLOT_FULL) && i_ready;

  // A load wins over a drain so a simultaneous load/drain keeps the slot FULL.
  always_comb begin
    w_state_next = r_state;
    if (i_load) begin
      w_state_next = SLOT_FULL;
    end else if (w_drain) begin
      w_state_next = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_load) begin
        r_data <= i_data;
      end
      if (w_drain) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/demux_1_4.sv
// 1-to-4 valid/ready demultiplexer: routes each upstream beat to the slot chosen by s_sel.
module demux_1_4
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  input  logic [SEL_W-1:0]        s_sel,
  output logic [NUM_CH-1:0]       m_valid,
  input  logic [NUM_CH-1:0]       m_ready,
  output logic [NUM_CH*WIDTH-1:0] m_data,
  output logic [NUM_CH*CNT_W-1:0] m_count
);

  logic [NUM_CH-1:0] w_load;

  // Ready depends only on slot occupancy and m_ready, never on s_valid.
  assign s_ready = ~m_valid[s_sel] | m_ready[s_sel];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign w_load[gi] = s_valid && s_ready && (s_sel == SEL_W'(gi));

      demux_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
      ) u_slot (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load[gi]),
        .i_data (s_data),
        .i_ready(m_ready[gi]),
        .o_valid(m_valid[gi]),
        .o_data (m_data[gi*WIDTH +: WIDTH]),
        .o_count(m_count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
